// File: rtl/factor_sequencer_if.sv
// Handshake and display bundle between the operand source and the factor sequencer.
// The master drives the operand and start request. The slave reports status and the displayed factor.
interface factor_sequencer_if;
    logic [7:0] number_in;
    logic       start;
    logic       busy;
    logic       done;
    logic       is_prime;
    logic [3:0] factor_count;
    logic [7:0] disp_factor;
    logic [2:0] disp_index;
    logic       disp_strobe;
    logic [7:0] dwell_lsb;

    modport master (
        output number_in, start,
        input  busy, done, is_prime, factor_count,
        input  disp_factor, disp_index, disp_strobe, dwell_lsb
    );

    modport slave (
        input  number_in, start,
        output busy, done, is_prime, factor_count,
        output disp_factor, disp_index, disp_strobe, dwell_lsb
    );
endinterface

// File: rtl/factor_sequencer.sv
// Prime factorizer sequencer: trial division by repeated subtraction, then cycles the buffered
// factors onto the display path with a MAX_COUNT-cycle dwell per factor.
module factor_sequencer #(
    parameter int MAX_COUNT = 10_000_000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    factor_sequencer_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIVIDE,
        CHECK,
        DISPLAY
    } state_t;

    localparam logic [31:0] DWELL_LAST = 32'(MAX_COUNT - 1);

    state_t      state_q, state_d;
    logic [7:0]  residue_q, residue_d;
    logic [7:0]  divisor_q, divisor_d;
    logic [7:0]  rem_q, rem_d;
    logic [7:0]  quot_q, quot_d;
    logic [3:0]  count_q, count_d;
    logic [7:0]  slot_q [8];
    logic [7:0]  slot_d [8];
    logic [31:0] dwell_q, dwell_d;
    logic [2:0]  dispIndex_q, dispIndex_d;
    logic        strobe;
    logic [15:0] nextSquare;
    logic [15:0] divisorWide;

    // State register; reset clears everything including the factor buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            residue_q   <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
            count_q     <= '0;
            dwell_q     <= '0;
            dispIndex_q <= '0;
            for (int i = 0; i < 8; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            residue_q   <= residue_d;
            divisor_q   <= divisor_d;
            rem_q       <= rem_d;
            quot_q      <= quot_d;
            count_q     <= count_d;
            dwell_q     <= dwell_d;
            dispIndex_q <= dispIndex_d;
            for (int i = 0; i < 8; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    // The square test decides whether the remaining residue must itself be prime.
    always_comb begin
        divisorWide = {8'd0, divisor_q} + 16'd1;
        nextSquare  = divisorWide * divisorWide;
    end

    // Next-state logic. Dwell and display index stay at zero outside DISPLAY.
    always_comb begin
        state_d     = state_q;
        residue_d   = residue_q;
        divisor_d   = divisor_q;
        rem_d       = rem_q;
        quot_d      = quot_q;
        count_d     = count_q;
        dwell_d     = '0;
        dispIndex_d = '0;
        strobe      = 1'b0;
        for (int i = 0; i < 8; i++) begin
            slot_d[i] = slot_q[i];
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    residue_d = bus.number_in;
                    count_d   = '0;
                    state_d   = LOAD;
                end
            end

            LOAD: begin
                if (residue_q < 8'd2) begin
                    slot_d[0] = residue_q;
                    count_d   = 4'd1;
                    state_d   = DISPLAY;
                end else begin
                    divisor_d = 8'd2;
                    rem_d     = residue_q;
                    quot_d    = '0;
                    state_d   = DIVIDE;
                end
            end

            DIVIDE: begin
                if (rem_q >= divisor_q) begin
                    rem_d  = rem_q - divisor_q;
                    quot_d = quot_q + 8'd1;
                end else begin
                    state_d = CHECK;
                end
            end

            CHECK: begin
                if (rem_q == 8'd0) begin
                    slot_d[count_q[2:0]] = divisor_q;
                    count_d              = count_q + 4'd1;
                    residue_d            = quot_q;
                    if (quot_q == 8'd1) begin
                        state_d = DISPLAY;
                    end else begin
                        rem_d   = quot_q;
                        quot_d  = '0;
                        state_d = DIVIDE;
                    end
                end else if (nextSquare > {8'd0, residue_q}) begin
                    slot_d[count_q[2:0]] = residue_q;
                    count_d              = count_q + 4'd1;
                    state_d              = DISPLAY;
                end else begin
                    divisor_d = divisor_q + 8'd1;
                    rem_d     = residue_q;
                    quot_d    = '0;
                    state_d   = DIVIDE;
                end
            end

            DISPLAY: begin
                if (bus.start) begin
                    residue_d = bus.number_in;
                    count_d   = '0;
                    state_d   = LOAD;
                end else if (dwell_q == DWELL_LAST) begin
                    strobe      = 1'b1;
                    dispIndex_d = ({1'b0, dispIndex_q} == count_q - 4'd1) ? 3'd0 : dispIndex_q + 3'd1;
                end else begin
                    dwell_d     = dwell_q + 32'd1;
                    dispIndex_d = dispIndex_q;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy         = (state_q == LOAD) || (state_q == DIVIDE) || (state_q == CHECK);
    assign bus.done         = (state_q == DISPLAY);
    assign bus.is_prime     = (state_q == DISPLAY) && (count_q == 4'd1) && (slot_q[0] >= 8'd2);
    assign bus.factor_count = count_q;
    assign bus.disp_factor  = slot_q[dispIndex_q];
    assign bus.disp_index   = dispIndex_q;
    assign bus.disp_strobe  = strobe;
    assign bus.dwell_lsb    = dwell_q[7:0];

endmodule
